// File: rtl/ha_cs_resolve.sv
// ---------------------------------------------------------------------------
// ha_cs_resolve
//   Resolves the carry-save pair from an N-bit half-adder array into one
//   binary value: result = sum + (cout << 1), W = N+1 bits wide.
//   The addition is a chunked ripple that handles CHUNK bits per cycle over
//   NCH = ceil(W/CHUNK) cycles. This keeps the per-cycle carry path short.
//   It also flags any bit position where both sum and cout are set. A half
//   adder can never produce that pair.
//
// Ports
//   clk        in   1     clock, rising edge
//   rst        in   1     synchronous active-high reset
//   in_valid   in   1     sum_i/cout_i valid
//   in_ready   out  1     operands accepted this cycle when in_valid is high
//   sum_i      in   N     half-adder sum bits (bit k weight 2^k)
//   cout_i     in   N     half-adder carry bits (bit k weight 2^(k+1))
//   out_valid  out  1     result_o/err_o valid
//   out_ready  in   1     consumer takes the result this cycle
//   result_o   out  N+1   resolved binary value
//   err_o      out  1     illegal pair seen (sum_i[k] & cout_i[k] for some k)
// ---------------------------------------------------------------------------
module ha_cs_resolve #(
   parameter int N     = 8,
   parameter int CHUNK = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] sum_i,
   input  logic [N-1:0] cout_i,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N:0]   result_o,
   output logic         err_o
);

   localparam int W   = N + 1;
   localparam int NCH = (W + CHUNK - 1) / CHUNK;
   localparam int PW  = NCH * CHUNK;
   localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;

   typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

   state_t          state;
   logic [PW-1:0]   a_q;
   logic [PW-1:0]   b_q;
   logic [PW-1:0]   res_q;
   logic [PW-1:0]   a_in;
   logic [PW-1:0]   b_in;
   logic [PW-1:0]   res_next;
   logic [IW-1:0]   idx;
   logic            carry;
   logic            err_q;
   logic [CHUNK:0]  csum;
   logic            last;

   // One ripple slice: CHUNK-bit add with carry in and carry out.
   function automatic logic [CHUNK:0] chunk_add(input logic [CHUNK-1:0] a,
                                                input logic [CHUNK-1:0] b,
                                                input logic             c);
      return {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, c};
   endfunction

   // A DONE-state handshake lets a new operand pair in on the same edge
   // that the current result leaves.
   assign in_ready = !rst && ((state == IDLE) || ((state == DONE) && out_ready));
   assign last     = (idx == IW'(NCH - 1));

   always_comb begin
      // Operands are zero-extended to a whole number of chunks.
      a_in           = '0;
      a_in[N-1:0]    = sum_i;
      b_in           = '0;
      b_in[N:1]      = cout_i;
      csum           = chunk_add(a_q[idx*CHUNK +: CHUNK], b_q[idx*CHUNK +: CHUNK], carry);
      res_next       = res_q;
      res_next[idx*CHUNK +: CHUNK] = csum[CHUNK-1:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         result_o  <= '0;
         err_o     <= 1'b0;
         out_valid <= 1'b0;
         idx       <= '0;
         carry     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_q   <= a_in;
                  b_q   <= b_in;
                  err_q <= |(sum_i & cout_i);
                  idx   <= '0;
                  carry <= 1'b0;
                  state <= ADD;
               end
            end
            ADD: begin
               res_q <= res_next;
               carry <= csum[CHUNK];
               idx   <= idx + 1'b1;
               // The final carry and any padding bits above W are dropped.
               // For legal pairs they are always zero.
               if (last) begin
                  result_o  <= res_next[W-1:0];
                  err_o     <= err_q;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  if (in_valid) begin
                     a_q   <= a_in;
                     b_q   <= b_in;
                     err_q <= |(sum_i & cout_i);
                     idx   <= '0;
                     carry <= 1'b0;
                     state <= ADD;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ha_cs_resolve.sv
module tb_ha_cs_resolve;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] sum_i;
   logic [7:0] cout_i;
   logic       out_ready;
   logic       iv4, iv1, iv9;
   logic       rdy4, rdy1, rdy9;
   logic       ov4, ov1, ov9;
   logic [8:0] res4, res1, res9;
   logic       err4, err1, err9;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   ha_cs_resolve #(.N(8), .CHUNK(4)) u_dut4 (
      .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(rdy4),
      .sum_i(sum_i), .cout_i(cout_i), .out_valid(ov4), .out_ready(out_ready),
      .result_o(res4), .err_o(err4));

   ha_cs_resolve #(.N(8), .CHUNK(1)) u_dut1 (
      .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(rdy1),
      .sum_i(sum_i), .cout_i(cout_i), .out_valid(ov1), .out_ready(out_ready),
      .result_o(res1), .err_o(err1));

   ha_cs_resolve #(.N(8), .CHUNK(9)) u_dut9 (
      .clk(clk), .rst(rst), .in_valid(iv9), .in_ready(rdy9),
      .sum_i(sum_i), .cout_i(cout_i), .out_valid(ov9), .out_ready(out_ready),
      .result_o(res9), .err_o(err9));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_iv(input int w, input logic v);
      if (w == 0) iv4 = v;
      else if (w == 1) iv1 = v;
      else iv9 = v;
   endtask

   function automatic logic get_ov(input int w);
      return (w == 0) ? ov4 : (w == 1) ? ov1 : ov9;
   endfunction

   function automatic logic get_rdy(input int w);
      return (w == 0) ? rdy4 : (w == 1) ? rdy1 : rdy9;
   endfunction

   function automatic logic [8:0] get_res(input int w);
      return (w == 0) ? res4 : (w == 1) ? res1 : res9;
   endfunction

   function automatic logic get_err(input int w);
      return (w == 0) ? err4 : (w == 1) ? err1 : err9;
   endfunction

   // Entered just after a rising edge. Presents one operand pair, measures the
   // cycles from the accept edge to out_valid, and checks the result. Returns
   // just after the edge that follows out_valid.
   task automatic run_op(input int w, input logic [7:0] s, input logic [7:0] c,
                         input logic [8:0] er, input logic ee, input int el,
                         input string tag);
      int k;
      set_iv(w, 1'b1);
      sum_i  = s;
      cout_i = c;
      @(negedge clk);
      check({tag, "_rdy"}, get_rdy(w), 1);
      @(posedge clk); #1;
      set_iv(w, 1'b0);
      sum_i  = 8'h00;
      cout_i = 8'h00;
      k = 31;
      for (int i = 1; i <= 30; i++) begin
         @(negedge clk);
         if (get_ov(w)) begin
            k = i;
            break;
         end
      end
      check({tag, "_lat"}, k, el);
      check({tag, "_res"}, get_res(w), er);
      check({tag, "_err"}, get_err(w), ee);
      @(posedge clk); #1;
   endtask

   initial begin
      logic [7:0] s, c;
      rst       = 1'b1;
      iv4       = 1'b0;
      iv1       = 1'b0;
      iv9       = 1'b0;
      out_ready = 1'b1;
      sum_i     = 8'h00;
      cout_i    = 8'h00;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_rdy", rdy4, 0);
      check("rst_ov", ov4, 0);
      check("rst_res", res4, 9'h000);
      check("rst_err", err4, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_rdy", rdy4, 1);
      @(posedge clk); #1;

      // Basic resolution, CHUNK=4
      run_op(0, 8'hFF, 8'h00, 9'h0FF, 1'b0, 4, "t1");
      @(negedge clk);
      check("idle_hold_res", res4, 9'h0FF);
      check("idle_ov", ov4, 0);
      @(posedge clk); #1;
      run_op(0, 8'h55, 8'hAA, 9'h1A9, 1'b0, 4, "t2a");
      run_op(0, 8'h00, 8'hFF, 9'h1FE, 1'b0, 4, "t2b");
      run_op(0, 8'h0F, 8'hF0, 9'h1EF, 1'b0, 4, "t2c");
      run_op(0, 8'h01, 8'h01, 9'h003, 1'b1, 4, "t3a");
      run_op(0, 8'hFF, 8'hFF, 9'h0FD, 1'b1, 4, "t3b");

      // Back-pressure, then a back-to-back accept on release
      out_ready = 1'b0;
      run_op(0, 8'h12, 8'h21, 9'h054, 1'b0, 4, "t4a");
      iv4    = 1'b1;
      sum_i  = 8'h80;
      cout_i = 8'h80;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("hold_ov", ov4, 1);
         check("hold_res", res4, 9'h054);
         check("hold_rdy", rdy4, 0);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      run_op(0, 8'h80, 8'h80, 9'h180, 1'b1, 4, "t4b");

      // Reset during the second ADD cycle
      iv4    = 1'b1;
      sum_i  = 8'hAA;
      cout_i = 8'h55;
      @(posedge clk); #1;
      iv4 = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      check("t5_rdy_in_rst", rdy4, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("t5_rdy", rdy4, 1);
      check("t5_ov", ov4, 0);
      check("t5_res", res4, 9'h000);
      check("t5_err", err4, 0);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("t5_no_ov", ov4, 0);
      end
      @(posedge clk); #1;

      // Parameter sweep: CHUNK=1 (latency 10) and CHUNK=9 (latency 2)
      run_op(1, 8'hFF, 8'h00, 9'h0FF, 1'b0, 10, "c1_dir");
      run_op(2, 8'h00, 8'hFF, 9'h1FE, 1'b0, 2, "c9_dir");
      for (int i = 0; i < 4; i++) begin
         s = 8'($urandom_range(0, 255));
         c = 8'($urandom_range(0, 255)) & ~s;
         run_op(1, s, c, {1'b0, s} + {c, 1'b0}, 1'b0, 10, $sformatf("c1_rnd%0d", i));
         s = 8'($urandom_range(0, 255));
         c = 8'($urandom_range(0, 255)) & ~s;
         run_op(2, s, c, {1'b0, s} + {c, 1'b0}, 1'b0, 2, $sformatf("c9_rnd%0d", i));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
